// File: rtl/ps_mm_pkg.sv
// rtl/ps_mm_pkg.sv - shared types and length helpers for the packet-stream memory reader
package ps_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    // Number of words needed to hold len symbols (ceil(len / symbols)); symbols is a power of 2.
    function automatic logic [31:0] words_of(input logic [31:0] len, input int symbols);
        logic [31:0] mask;
        mask = 32'(symbols - 1);
        return (len >> $clog2(symbols)) + {31'd0, |(len & mask)};
    endfunction

    // Empty high-index symbols in the last word: (symbols - len mod symbols) mod symbols.
    function automatic logic [31:0] mty_of(input logic [31:0] len, input int symbols);
        logic [31:0] mask;
        mask = 32'(symbols - 1);
        return (32'(symbols) - (len & mask)) & mask;
    endfunction

endpackage

// File: rtl/ps_mm_reader_if.sv
// rtl/ps_mm_reader_if.sv - Avalon-MM read bus bundle with master/slave views
interface ps_mm_reader_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] address;
    logic              read;
    logic [DWIDTH-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address,
        output read,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        output readdatavalid,
        output waitrequest
    );
endinterface

// File: rtl/ps_mm_read_buffer.sv
// rtl/ps_mm_read_buffer.sv - show-ahead FIFO that absorbs read responses under backpressure
module ps_mm_read_buffer #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   used
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_rd;

    assign rd_data = mem[rd_ptr];
    assign empty   = (used == '0);
    assign do_rd   = rd_en & ~empty;

    // Storage, pointers and occupancy; the head word is always visible on rd_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            used <= used + UW'(wr_en) - UW'(do_rd);
        end
    end
endmodule

// File: rtl/ps_mm_reader.sv
// rtl/ps_mm_reader.sv - replays one packet from memory as a packet stream via pipelined reads
module ps_mm_reader
    import ps_mm_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 8,
    parameter int SYMBOLS = 4,
    parameter int LWIDTH  = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic [AWIDTH-1:0]          cmd_addr,
    input  logic [LWIDTH-1:0]          cmd_len,
    input  logic                       cmd_val,
    output logic                       cmd_rdy,
    output logic [DWIDTH-1:0]          o_dat,
    output logic [$clog2(SYMBOLS)-1:0] o_mty,
    output logic                       o_val,
    output logic                       o_eop,
    input  logic                       o_rdy,
    ps_mm_reader_if.master             avm
);
    localparam int WW = LWIDTH + 1;
    localparam int MW = $clog2(SYMBOLS);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    state_t            state;
    logic [AWIDTH-1:0] addr;
    logic              rd;
    logic [WW-1:0]     words;
    logic [WW-1:0]     issued;
    logic [WW-1:0]     consumed;
    logic [MW-1:0]     last_mty;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     used;
    logic              buf_empty;
    logic              accept;
    logic              rdv;
    logic              pop;
    logic [WW-1:0]     cmd_words;
    logic [MW-1:0]     cmd_mty;
    logic [WW-1:0]     issued_n;
    logic [CW-1:0]     out_n;
    logic [CW-1:0]     used_n;
    logic [CW:0]       credit;
    logic              rd_next;

    assign avm.address = addr;
    assign avm.read    = rd;
    assign accept      = rd & ~avm.waitrequest;
    assign rdv         = avm.readdatavalid;
    assign o_val       = ~buf_empty;
    assign pop         = o_val & o_rdy;
    assign o_eop       = o_val & (consumed == words - WW'(1));
    assign o_mty       = o_eop ? last_mty : '0;

    ps_mm_read_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rdv),
        .wr_data (avm.readdata),
        .rd_en   (pop),
        .rd_data (o_dat),
        .empty   (buf_empty),
        .used    (used)
    );

    // Next-cycle credit: a new read may go out only if in-flight plus buffered words stay below DEPTH.
    always_comb begin
        cmd_words = WW'(words_of(32'(cmd_len), SYMBOLS));
        cmd_mty   = MW'(mty_of(32'(cmd_len), SYMBOLS));
        issued_n  = issued + WW'(accept);
        out_n     = outstanding + CW'(accept) - CW'(rdv);
        used_n    = used + CW'(rdv) - CW'(pop);
        credit    = {1'b0, out_n} + {1'b0, used_n};
        rd_next   = (rd & avm.waitrequest) | ((issued_n < words) & (credit < DEPTH_W));
    end

    // Command accept, read issue and end-of-packet sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_rdy     <= 1'b0;
            rd          <= 1'b0;
            addr        <= '0;
            words       <= '0;
            last_mty    <= '0;
            issued      <= '0;
            consumed    <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= out_n;
            if (pop) consumed <= consumed + WW'(1);
            case (state)
                IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (cmd_val && cmd_rdy && cmd_len != '0) begin
                        addr     <= cmd_addr;
                        words    <= cmd_words;
                        last_mty <= cmd_mty;
                        issued   <= '0;
                        consumed <= '0;
                        rd       <= 1'b1;
                        cmd_rdy  <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    issued <= issued_n;
                    if (accept) addr <= addr + 1'b1;
                    if (issued_n == words) begin
                        rd    <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd <= rd_next;
                    end
                end
                DRAIN: begin
                    if (pop && o_eop) begin
                        cmd_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps_mm_reader.sv
// tb/tb_ps_mm_reader.sv - directed and randomized checks of ps_mm_reader against a memory model
module tb_ps_mm_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  o_dat;
    logic [1:0]  o_mty;
    logic        o_val;
    logic        o_eop;
    logic        o_rdy = 1'b0;

    ps_mm_reader_if #(.DWIDTH(8), .AWIDTH(8)) avm ();

    ps_mm_reader dut (
        .reset    (reset),
        .clk      (clk),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_val  (cmd_val),
        .cmd_rdy  (cmd_rdy),
        .o_dat    (o_dat),
        .o_mty    (o_mty),
        .o_val    (o_val),
        .o_eop    (o_eop),
        .o_rdy    (o_rdy),
        .avm      (avm)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    int rdy_mode = 1;
    int wait_mode = 0;
    int acc_total = 0;
    int pop_total = 0;
    int read_seen = 0;
    int val_seen = 0;
    logic [7:0]  mem [256];
    logic [7:0]  pend_a [$];
    int          pend_t [$];
    logic [7:0]  addr_q [$];
    logic [10:0] out_q [$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic        pend_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory slave: fixed latency, optional random waitrequest, in-order responses.
    always @(negedge clk) begin
        if (!reset) begin
            avm.readdatavalid = 1'b0;
            avm.waitrequest   = 1'b0;
            pend_a.delete();
            pend_t.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_read", avm.read, 1);
                check("hold_addr", avm.address, prev_addr);
            end
            if (pend_t.size() > 0 && pend_t[0] == cyc + 1) begin
                avm.readdatavalid = 1'b1;
                avm.readdata      = mem[pend_a[0]];
                void'(pend_a.pop_front());
                void'(pend_t.pop_front());
            end else begin
                avm.readdatavalid = 1'b0;
                avm.readdata      = 8'($urandom);
            end
            avm.waitrequest = (wait_mode != 0) && ($urandom_range(0, 2) == 0);
            if (avm.read) read_seen++;
            if (avm.read && !avm.waitrequest) begin
                pend_a.push_back(avm.address);
                pend_t.push_back(cyc + 1 + lat);
                addr_q.push_back(avm.address);
                acc_total++;
                check("credit", ((acc_total - pop_total) <= 4) ? 1 : 0, 1);
            end
            prev_stall = avm.read && avm.waitrequest;
            prev_addr  = avm.address;
        end
    end

    // Stream sink: drives o_rdy and records every consumed word.
    always @(negedge clk) begin
        if (pend_rdy) begin
            check("eop_to_cmd_rdy", cmd_rdy, 1);
            pend_rdy = 1'b0;
        end
        case (rdy_mode)
            0:       o_rdy = 1'b0;
            1:       o_rdy = 1'b1;
            default: o_rdy = 1'($urandom_range(0, 1));
        endcase
        if (o_val) val_seen++;
        if (reset && o_val && o_rdy) begin
            out_q.push_back({o_eop, o_mty, o_dat});
            pop_total++;
            if (o_eop) pend_rdy = 1'b1;
        end
    end

    task automatic send_cmd(input logic [7:0] a, input logic [15:0] len);
        int to;
        to = 0;
        while (cmd_rdy !== 1'b1 && to < 300) begin
            @(negedge clk);
            to++;
        end
        check("cmd_rdy_wait", cmd_rdy, 1);
        out_q.delete();
        addr_q.delete();
        cmd_addr = a;
        cmd_len  = len;
        cmd_val  = 1'b1;
        @(negedge clk);
        cmd_val = 1'b0;
        if (len != 0) begin
            check("read_start", avm.read, 1);
            check("addr_start", avm.address, a);
        end
    endtask

    task automatic finish_cmd(input logic [7:0] a, input logic [15:0] len);
        int nw;
        int lm;
        int to;
        logic [7:0]  ea;
        logic [10:0] exp_w;
        nw = (int'(len) + 3) / 4;
        lm = (4 - int'(len) % 4) % 4;
        to = 0;
        while (out_q.size() < nw && to < 3000) begin
            @(negedge clk);
            to++;
        end
        check("words_out", out_q.size(), nw);
        for (int i = 0; i < nw && i < out_q.size(); i++) begin
            ea    = 8'(int'(a) + i);
            exp_w = {(i == nw - 1), (i == nw - 1) ? 2'(lm) : 2'd0, mem[ea]};
            check($sformatf("word%0d", i), 32'(out_q[i]), 32'(exp_w));
            if (i < addr_q.size()) check($sformatf("addr%0d", i), 32'(addr_q[i]), 32'(ea));
        end
        repeat (2) @(negedge clk);
        check("reads_issued", addr_q.size(), nw);
    endtask

    initial begin
        int a0;
        int r0;
        int v0;
        int to;
        logic [7:0]  ra;
        logic [15:0] rl;
        avm.readdatavalid = 1'b0;
        avm.waitrequest   = 1'b0;
        avm.readdata      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_read", avm.read, 0);
        check("rst_address", avm.address, 0);
        check("rst_o_val", o_val, 0);
        check("rst_o_eop", o_eop, 0);
        check("rst_o_mty", o_mty, 0);
        check("rst_o_dat", o_dat, 0);
        reset = 1'b1;
        #1 check("cmd_rdy_before_clk", cmd_rdy, 0);
        @(negedge clk);
        check("cmd_rdy_after_clk", cmd_rdy, 1);

        lat = 1; rdy_mode = 1; wait_mode = 0;
        send_cmd(8'h10, 16'd8);
        finish_cmd(8'h10, 16'd8);
        send_cmd(8'h30, 16'd5);
        finish_cmd(8'h30, 16'd5);
        send_cmd(8'h50, 16'd1);
        finish_cmd(8'h50, 16'd1);

        lat = 3; rdy_mode = 0;
        a0 = acc_total;
        send_cmd(8'h40, 16'd32);
        repeat (20) @(negedge clk);
        check("bp_reads_before_stall", acc_total - a0, 4);
        check("bp_no_output", out_q.size(), 0);
        rdy_mode = 1;
        finish_cmd(8'h40, 16'd32);

        lat = 2; wait_mode = 1;
        send_cmd(8'hFE, 16'd16);
        finish_cmd(8'hFE, 16'd16);
        wait_mode = 0;

        r0 = read_seen;
        v0 = val_seen;
        send_cmd(8'h70, 16'd0);
        check("zero_len_cmd_rdy", cmd_rdy, 1);
        repeat (8) @(negedge clk);
        check("zero_len_no_read", read_seen, r0);
        check("zero_len_no_val", val_seen, v0);

        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom);
            rl = 16'($urandom_range(1, 40));
            lat = $urandom_range(1, 3);
            rdy_mode = 2;
            wait_mode = $urandom_range(0, 1);
            send_cmd(ra, rl);
            finish_cmd(ra, rl);
        end

        lat = 1; rdy_mode = 1; wait_mode = 0;
        send_cmd(8'h80, 16'd16);
        to = 0;
        while (out_q.size() < 2 && to < 200) begin
            @(negedge clk);
            to++;
        end
        check("pre_reset_words", (out_q.size() >= 2) ? 1 : 0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_rdy", cmd_rdy, 0);
        check("mid_rst_read", avm.read, 0);
        check("mid_rst_address", avm.address, 0);
        check("mid_rst_o_val", o_val, 0);
        check("mid_rst_o_eop", o_eop, 0);
        check("mid_rst_o_mty", o_mty, 0);
        check("mid_rst_o_dat", o_dat, 0);
        reset = 1'b1;
        acc_total = 0;
        pop_total = 0;
        pend_rdy  = 1'b0;
        send_cmd(8'h20, 16'd4);
        finish_cmd(8'h20, 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
